// File: rtl/pe_pkg.sv
// pe_pkg: state encodings and saturation bounds shared by the pe_acc processing element.
package pe_pkg;
    typedef enum logic {ST_EMPTY = 1'b0, ST_ACCUM = 1'b1} state_t;
    localparam int BOUND_W = 66;
    typedef logic signed [BOUND_W-1:0] bound_t;
    function automatic bound_t sat_max(input int k, input logic sn);
        return sn ? (bound_t'(1) <<< (k - 1)) - bound_t'(1) : (bound_t'(1) <<< k) - bound_t'(1);
    endfunction
    function automatic bound_t sat_min(input int k, input logic sn);
        return sn ? -(bound_t'(1) <<< (k - 1)) : '0;
    endfunction
endpackage

// File: rtl/pe_sat.sv
// pe_sat: combinational ACC_W->K saturate/truncate with an out-of-range flag.
module pe_sat
    import pe_pkg::*;
#(
    parameter int ACC_W = 24,
    parameter int K     = 8
) (
    input  logic [ACC_W-1:0] val,
    input  logic             sn,
    input  logic             sat_en,
    output logic [K-1:0]     res,
    output logic             ovf
);
    bound_t v;
    logic hi, lo;
    always_comb begin
        v   = sn ? bound_t'($signed(val)) : bound_t'({1'b0, val});
        hi  = v > sat_max(K, sn);
        lo  = v < sat_min(K, sn);
        ovf = hi | lo;
        res = !sat_en ? val[K-1:0] : hi ? K'(sat_max(K, sn)) : lo ? K'(sat_min(K, sn)) : val[K-1:0];
    end
endmodule

// File: rtl/pe_acc.sv
// pe_acc: systolic PE forwarding operands east/south, multiplying, accumulating a
// tile and handing the saturated result downstream over valid/ready.
module pe_acc
    import pe_pkg::*;
#(
    parameter int N     = 8,
    parameter int K     = 8,
    parameter int ACC_W = 2*N+8
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         sn,
    input  logic         sat_en,
    input  logic         in_vld,
    input  logic         in_last,
    input  logic [N-1:0] a_in,
    input  logic [N-1:0] b_in,
    output logic [N-1:0] a_out,
    output logic [N-1:0] b_out,
    output logic         vld_out,
    output logic         last_out,
    output logic [K-1:0] res_data,
    output logic         res_ovf,
    output logic         res_vld,
    input  logic         res_rdy,
    output logic         stall
);
    state_t state;
    logic [2*N-1:0] p1, a_x, b_x;
    logic p1_vld, p1_last, load, wrap, wrap_base, carry, step_wrap, sat_ovf;
    logic [ACC_W-1:0] acc, base, ext, sum;
    logic [K-1:0] sat_res;

    assign stall = res_vld & ~res_rdy & p1_vld & p1_last;
    assign load  = p1_vld & p1_last & ~stall;

    // Operands are widened per sn so one 2N x 2N multiply serves both signednesses.
    always_comb begin
        a_x          = sn ? (2*N)'($signed(a_out)) : (2*N)'(a_out);
        b_x          = sn ? (2*N)'($signed(b_out)) : (2*N)'(b_out);
        base         = state == ST_EMPTY ? '0 : acc;
        wrap_base    = state == ST_ACCUM & wrap;
        ext          = sn ? ACC_W'($signed(p1)) : ACC_W'(p1);
        {carry, sum} = {1'b0, base} + {1'b0, ext};
        step_wrap    = sn ? (base[ACC_W-1] == ext[ACC_W-1]) & (sum[ACC_W-1] != base[ACC_W-1]) : carry;
    end

    pe_sat #(.ACC_W(ACC_W), .K(K)) u_sat (
        .val(sum), .sn(sn), .sat_en(sat_en), .res(sat_res), .ovf(sat_ovf)
    );

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state    <= ST_EMPTY;
            a_out    <= '0;
            b_out    <= '0;
            vld_out  <= 1'b0;
            last_out <= 1'b0;
            p1       <= '0;
            p1_vld   <= 1'b0;
            p1_last  <= 1'b0;
            acc      <= '0;
            wrap     <= 1'b0;
            res_data <= '0;
            res_ovf  <= 1'b0;
            res_vld  <= 1'b0;
        end else begin
            if (!stall) begin
                vld_out  <= in_vld;
                last_out <= in_vld & in_last;
                p1_vld   <= vld_out;
                p1_last  <= last_out;
                if (in_vld) begin
                    a_out <= a_in;
                    b_out <= b_in;
                end
                if (vld_out) p1 <= a_x * b_x;
            end
            if (p1_vld & !stall) begin
                state <= p1_last ? ST_EMPTY : ST_ACCUM;
                acc   <= p1_last ? '0 : sum;
                wrap  <= !p1_last & (wrap_base | step_wrap);
            end
            if (load) begin
                res_data <= sat_res;
                res_ovf  <= sat_ovf | wrap_base | step_wrap;
            end
            res_vld <= load | (res_vld & !res_rdy);
        end
    end
endmodule

// File: tb/tb_pe_acc.sv
// tb_pe_acc: directed vector table, multi-cycle corner sequences and a randomized
// stream scored against a tile-level arithmetic model of pe_acc.
module tb_pe_acc;
    localparam int N = 8, K = 8, ACC_W = 24;

    logic clk = 0, rst = 1, sn = 0, sat_en = 0, in_vld = 0, in_last = 0, res_rdy = 1;
    logic [N-1:0] a_in = 0, b_in = 0, a_out, b_out;
    logic vld_out, last_out, res_ovf, res_vld, stall;
    logic [K-1:0] res_data;
    int tests = 0, fails = 0;

    typedef struct packed {
        logic [1:0]      n;
        logic            sgn;
        logic            sat;
        logic [2:0][7:0] a;
        logic [2:0][7:0] b;
        logic [7:0]      d;
        logic            o;
    } vec_t;
    vec_t vt[12];

    always #5 clk = ~clk;

    pe_acc #(.N(N), .K(K), .ACC_W(ACC_W)) dut (
        .clk(clk), .rst(rst), .sn(sn), .sat_en(sat_en), .in_vld(in_vld), .in_last(in_last),
        .a_in(a_in), .b_in(b_in), .a_out(a_out), .b_out(b_out), .vld_out(vld_out),
        .last_out(last_out), .res_data(res_data), .res_ovf(res_ovf), .res_vld(res_vld),
        .res_rdy(res_rdy), .stall(stall)
    );

    task automatic check(input string name, input longint act, input longint exp);
        tests++;
        if (act != exp) begin
            fails++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    function automatic vec_t mk(input int n, input logic sg, input logic st, input logic [23:0] av,
                                input logic [23:0] bv, input logic [7:0] d, input logic o);
        vec_t v;
        v.n = 2'(n);
        v.sgn = sg;
        v.sat = st;
        v.a = av;
        v.b = bv;
        v.d = d;
        v.o = o;
        return v;
    endfunction

    // Reference: clamp or truncate an exact integer tile sum; returns {ovf, data}.
    function automatic logic [K:0] model(input longint s, input logic sgn, input logic sat);
        longint mx, mn;
        logic o;
        mx = sgn ? (longint'(1) << (K - 1)) - 1 : (longint'(1) << K) - 1;
        mn = sgn ? -(longint'(1) << (K - 1)) : 0;
        o = s > mx || s < mn;
        return {o, (sat && s > mx) ? K'(mx) : (sat && s < mn) ? K'(mn) : K'(s)};
    endfunction

    task automatic run_vec(input vec_t v, input int idx);
        sn = v.sgn;
        sat_en = v.sat;
        res_rdy = 1;
        for (int i = 0; i < int'(v.n); i++) begin
            in_vld = 1;
            a_in = v.a[i];
            b_in = v.b[i];
            in_last = (i == int'(v.n) - 1);
            step();
        end
        in_vld = 0;
        in_last = 0;
        step();
        check($sformatf("vec%0d early vld", idx), res_vld, 0);
        step();
        check($sformatf("vec%0d vld", idx), res_vld, 1);
        check($sformatf("vec%0d data", idx), res_data, v.d);
        check($sformatf("vec%0d ovf", idx), res_ovf, v.o);
        step();
    endtask

    task automatic random_pass(input logic sgn, input logic sat, input int cycles);
        longint sum;
        int len;
        logic [K:0] q[$];
        logic [K:0] e;
        logic pend, drain, acc_now, hs, ev, el;
        logic [N-1:0] ea, eb;
        sum = 0;
        len = 0;
        pend = 0;
        ev = vld_out;
        el = last_out;
        ea = a_out;
        eb = b_out;
        sn = sgn;
        sat_en = sat;
        for (int c = 0; c < cycles + 40; c++) begin
            drain = c >= cycles;
            if (!pend) begin
                in_vld = drain ? len > 0 : $urandom_range(9) < 7;
                a_in = N'($urandom);
                b_in = N'($urandom);
                in_last = drain || len == 15 || $urandom_range(3) == 0;
            end
            res_rdy = drain || $urandom_range(9) < 7;
            @(negedge clk);
            acc_now = in_vld & ~stall;
            hs = res_vld & res_rdy;
            if (hs) begin
                if (q.size() == 0) check("rnd unexpected result", 1, 0);
                else begin
                    e = q.pop_front();
                    check("rnd data", res_data, e[K-1:0]);
                    check("rnd ovf", res_ovf, e[K]);
                end
            end
            if (!stall) begin
                ev = in_vld;
                el = in_vld & in_last;
                if (in_vld) begin
                    ea = a_in;
                    eb = b_in;
                end
            end
            if (acc_now) begin
                sum += sgn ? longint'($signed(a_in)) * longint'($signed(b_in)) : longint'(a_in) * longint'(b_in);
                len++;
                if (in_last) begin
                    q.push_back(model(sum, sgn, sat));
                    sum = 0;
                    len = 0;
                end
            end
            pend = in_vld & stall;
            step();
            check("rnd vld_out", vld_out, ev);
            if (ev) check("rnd fwd", {a_out, b_out, last_out}, {ea, eb, el});
        end
        in_vld = 0;
        check("rnd queue drained", q.size(), 0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "timeout");
    end

    initial begin
        vt[0]  = mk(3, 0, 0, 24'h050403, 24'h020202, 8'h18, 0);
        vt[1]  = mk(1, 1, 0, 24'h0000FD, 24'h000005, 8'hF1, 0);
        vt[2]  = mk(2, 1, 1, 24'h007F7F, 24'h007F7F, 8'h7F, 1);
        vt[3]  = mk(2, 1, 0, 24'h007F7F, 24'h007F7F, 8'h02, 1);
        vt[4]  = mk(1, 0, 1, 24'h0000FF, 24'h0000FF, 8'hFF, 1);
        vt[5]  = mk(1, 1, 1, 24'h000080, 24'h00007F, 8'h80, 1);
        vt[6]  = mk(1, 1, 1, 24'h00007F, 24'h000001, 8'h7F, 0);
        vt[7]  = mk(1, 1, 1, 24'h000080, 24'h000001, 8'h80, 0);
        vt[8]  = mk(1, 1, 0, 24'h0000FF, 24'h0000FF, 8'h01, 0);
        vt[9]  = mk(2, 0, 0, 24'h00F010, 24'h000110, 8'hF0, 1);
        vt[10] = mk(1, 1, 1, 24'h000080, 24'h000080, 8'h7F, 1);
        vt[11] = mk(3, 1, 0, 24'h0102FE, 24'h010203, 8'hFF, 0);

        #2 rst = 0;
        step();
        step();
        check("reset outputs", {a_out, b_out, vld_out, last_out, res_data, res_ovf, res_vld}, 0);
        check("reset stall", stall, 0);
        #3 rst = 1;
        step();

        // Reset mid-tile discards the partial sum and clears every output.
        in_vld = 1;
        a_in = 3;
        b_in = 2;
        in_last = 0;
        step();
        in_vld = 0;
        check("pre-reset a_out", a_out, 3);
        step();
        step();
        #2 rst = 0;
        #1;
        check("mid-tile reset outputs", {a_out, b_out, vld_out, last_out, res_data, res_ovf, res_vld}, 0);
        #2 rst = 1;
        step();
        run_vec(mk(1, 0, 0, 24'h000001, 24'h000001, 8'h01, 0), 100);

        for (int i = 0; i < 12; i++) run_vec(vt[i], i);

        // Accumulator wrap: 258 x 65025 + 768 carries out of 24 bits to leave 2.
        sn = 0;
        sat_en = 1;
        res_rdy = 1;
        for (int i = 0; i < 259; i++) begin
            in_vld = 1;
            a_in = i < 258 ? 8'hFF : 8'd32;
            b_in = i < 258 ? 8'hFF : 8'd24;
            in_last = i == 258;
            step();
        end
        in_vld = 0;
        in_last = 0;
        step();
        step();
        check("wrap vld", res_vld, 1);
        check("wrap data", res_data, 2);
        check("wrap ovf", res_ovf, 1);
        step();
        run_vec(mk(1, 0, 1, 24'h000001, 24'h000001, 8'h01, 0), 101);

        // Backpressure: two single-pair tiles with the result port blocked.
        sn = 0;
        sat_en = 0;
        res_rdy = 0;
        in_vld = 1;
        in_last = 1;
        a_in = 2;
        b_in = 3;
        step();
        a_in = 4;
        b_in = 5;
        step();
        check("bp fwd", {vld_out, last_out, a_out, b_out}, {1'b1, 1'b1, 8'd4, 8'd5});
        check("bp no stall yet", stall, 0);
        in_vld = 0;
        in_last = 0;
        step();
        check("bp first vld", res_vld, 1);
        check("bp first data", res_data, 6);
        check("bp stall", stall, 1);
        in_vld = 1;
        a_in = 9;
        b_in = 9;
        step();
        check("bp held data", res_data, 6);
        check("bp stall held", stall, 1);
        check("bp fwd frozen", vld_out, 0);
        in_vld = 0;
        res_rdy = 1;
        #1;
        check("bp stall released", stall, 0);
        step();
        check("bp second vld", res_vld, 1);
        check("bp second data", res_data, 20);
        check("bp fwd after", vld_out, 0);
        step();
        check("bp drained", res_vld, 0);

        random_pass(0, 0, 300);
        random_pass(0, 1, 300);
        random_pass(1, 0, 300);
        random_pass(1, 1, 300);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
